// File: rtl/serial_carry_adder.sv
// ---------------------------------------------------------------------------
// serial_carry_adder
//
// Multi-cycle adder that adds two WIDTH-bit operands plus a carry-in,
// DIGIT bits per clock, passing the carry between digit slices through a
// register. Operands are accepted with a valid/ready handshake and the
// result is offered with a second valid/ready handshake. One operation is
// in flight at a time: accept -> N = WIDTH/DIGIT RUN steps -> DONE -> IDLE.
//
// Parameters:
//   WIDTH      operand width in bits
//   DIGIT      bits added per clock (must divide WIDTH evenly)
//   OUT_WIDTH  sum port width (must be >= WIDTH+1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands a, b, cin are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum and cout are valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        {zeros, carry-out, (a+b+cin) mod 2^WIDTH}
//   cout       final carry-out, same as sum[WIDTH]
//   ovf        (only with SERIAL_ADDER_OVF_EN) signed two's-complement
//              overflow of the addition, held alongside sum
//
// Configuration macro:
//   SERIAL_ADDER_OVF_EN  adds the ovf output port and its logic.
// ---------------------------------------------------------------------------
module serial_carry_adder #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] sum,
    output logic                 cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                 ovf
`endif
);

    // Guarded divisor so a zero DIGIT reaches the elaboration check below
    // instead of tripping a divide-by-zero first.
    localparam int SAFE_DIGIT = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N          = WIDTH / SAFE_DIGIT;
    localparam int CW         = (N > 1) ? $clog2(N) : 1;

    // Reject illegal parameter combinations at elaboration time.
    generate
        if ((DIGIT < 1) || ((WIDTH % SAFE_DIGIT) != 0)) begin : g_badDigit
            $error("serial_carry_adder: DIGIT (%0d) must be >= 1 and divide WIDTH (%0d)",
                   DIGIT, WIDTH);
        end
        if (OUT_WIDTH < (WIDTH + 1)) begin : g_badOutWidth
            $error("serial_carry_adder: OUT_WIDTH (%0d) must be >= WIDTH+1 (%0d)",
                   OUT_WIDTH, WIDTH + 1);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [WIDTH-1:0]       r_aShift;
    logic [WIDTH-1:0]       r_bShift;
    logic [WIDTH-1:0]       r_result;
    logic                   r_carry;
    logic [CW-1:0]          r_count;
    logic [OUT_WIDTH-1:0]   r_sum;
    logic                   r_cout;

    logic [DIGIT:0]         w_slice;
    logic                   w_sliceCarry;
    logic [WIDTH+DIGIT-1:0] w_resultWide;
    logic [WIDTH-1:0]       w_resultNext;
    logic [OUT_WIDTH-1:0]   w_sumNext;
    logic                   w_lastStep;

`ifdef SERIAL_ADDER_OVF_EN
    logic                   r_ovf;
    logic                   w_msbCarryIn;
`endif

    // One digit slice of the ripple adder: low DIGIT bits of each operand
    // plus the carry left over from the previous step.
    assign w_slice      = {1'b0, r_aShift[DIGIT-1:0]}
                        + {1'b0, r_bShift[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, r_carry};
    assign w_sliceCarry = w_slice[DIGIT];

    // The new digit enters at the top and the result shifts right, so after
    // N steps the first digit computed sits in the least-significant place.
    // Going through a WIDTH+DIGIT wide vector keeps this legal for DIGIT=WIDTH.
    assign w_resultWide = {w_slice[DIGIT-1:0], r_result};
    assign w_resultNext = w_resultWide[WIDTH+DIGIT-1:DIGIT];

    // Final result as seen on the sum port, zero-extended above the carry.
    assign w_sumNext    = OUT_WIDTH'({w_sliceCarry, w_resultNext});

    assign w_lastStep   = (r_count == CW'(N - 1));

`ifdef SERIAL_ADDER_OVF_EN
    // On the last step the slice MSB is the operand MSB. The carry into a
    // full-adder bit equals a ^ b ^ s at that bit, which avoids tapping the
    // internal carry chain of the slice adder.
    assign w_msbCarryIn = w_slice[DIGIT-1] ^ r_aShift[DIGIT-1] ^ r_bShift[DIGIT-1];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and handshake outputs. Accept and complete never
    // overlap: in_ready is only high in IDLE and out_valid only in DONE.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_lastStep) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, step one digit per RUN cycle and
    // latch the finished result on the last step. The output registers are
    // only written on that last step, so they hold through DONE and IDLE
    // until the next operation completes; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aShift <= '0;
            r_bShift <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_aShift <= a;
                        r_bShift <= b;
                        r_result <= '0;
                        r_carry  <= cin;
                        r_count  <= '0;
                    end
                end
                ST_RUN: begin
                    r_aShift <= r_aShift >> DIGIT;
                    r_bShift <= r_bShift >> DIGIT;
                    r_result <= w_resultNext;
                    r_carry  <= w_sliceCarry;
                    r_count  <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_sum  <= w_sumNext;
                        r_cout <= w_sliceCarry;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf  <= w_msbCarryIn ^ w_sliceCarry;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_carry_adder
//
// Self-checking bench for serial_carry_adder at WIDTH=16, DIGIT=4 (N=4).
// Expected results are pushed to a scoreboard queue when an operation is
// handed to the DUT and popped when the DUT presents its result. Honours
// SERIAL_ADDER_OVF_EN so the same bench covers the ovf output.
// ---------------------------------------------------------------------------
module tb_serial_carry_adder;

    localparam int WIDTH     = 16;
    localparam int DIGIT     = 4;
    localparam int OUT_WIDTH = 32;
    localparam int N         = WIDTH / DIGIT;
    localparam int BUDGET    = 4 * N + 10;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] sum;
    logic                 cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic                 ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [31:0]      expSum;
        logic             expCout;
        logic             expOvf;
        bit               readyEarly;
        int               hold;
        bit               scramble;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   checks;
    int   errors;

    serial_carry_adder #(
        .WIDTH    (WIDTH),
        .DIGIT    (DIGIT),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check funnels through here.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain wide addition, overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic ic);
        exp_t        e;
        logic [16:0] s;
        s      = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
        e.sum  = {15'd0, s};
        e.cout = s[16];
        e.ovf  = (ia[15] == ib[15]) && (s[15] != ia[15]);
        return e;
    endfunction

    // Offer one operation in IDLE and record what it must produce. Returns on
    // the negedge just after the acceptance edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic ic, input exp_t e);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; in_ready must stay low meanwhile. When
    // scramble is set the input pins are thrown around while the DUT is busy.
    task automatic waitResult(input bit scramble, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid) begin
                seen     = 1'b1;
                lat      = c - 1;
                in_valid = 1'b0;
                break;
            end
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (scramble) begin
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'($urandom);
            end
        end
        check("result_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Pop the expected result, compare, optionally apply backpressure, then
    // complete the handshake and confirm the result is held in IDLE.
    task automatic checkOutput(input int hold);
        exp_t e;
        check("scoreboard_depth", sb.size(), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", sum, e.sum);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_sum_held", sum, e.sum);
        check("post_cout_held", {31'd0, cout}, {31'd0, e.cout});
    endtask

    initial begin
        int   lat;
        bit   seen;
        exp_t e;
        bit   sawValid;

        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // a, b, cin, sum, cout, ovf, readyEarly, hold, scramble
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0001_FFFF, 1'b1, 1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 5, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 32'h0001_0000, 1'b1, 1'b1, 1'b1, 0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 2, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            e.sum  = vecs[i].expSum;
            e.cout = vecs[i].expCout;
            e.ovf  = vecs[i].expOvf;
            out_ready = vecs[i].readyEarly;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, e);
            waitResult(vecs[i].scramble, lat, seen);
            if (seen) begin
                check("latency", lat, N);
                checkOutput(vecs[i].hold);
            end else begin
                sb.delete();
            end
            out_ready = 1'b0;
        end

        // Random operands against the model.
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc, model(ra, rb, rc));
            waitResult(1'b0, lat, seen);
            if (seen) begin
                check("rand_latency", lat, N);
                checkOutput(i % 3);
            end else begin
                sb.delete();
            end
        end

        // Reset during the second RUN cycle aborts the operation.
        applyStimulus(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_sum", sum, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        sawValid = 1'b0;
        out_ready = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        out_ready = 1'b0;
        check("abort_no_result", {31'd0, sawValid}, 32'd0);

        // Clean operation after the abort.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, model(16'h00FF, 16'h0001, 1'b0));
        waitResult(1'b0, lat, seen);
        if (seen) begin
            check("after_abort_latency", lat, N);
            check("after_abort_sum_exp", sum, 32'h0000_0100);
            checkOutput(0);
        end else begin
            sb.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_carry_adder.md
Name: serial_carry_adder

Overview:
- Parametrised multi-cycle successor to the combinational 16-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between digit slices.
- Sits behind a valid/ready handshake on both sides, so datapath blocks can trade adder area for latency.
- Result is zero-extended to OUT_WIDTH, with carry-out at bit WIDTH.

Parameters:
WIDTH, 16, operand width in bits.
DIGIT, 4, bits added per cycle; must divide WIDTH evenly. DIGIT=WIDTH gives a single-step add.
OUT_WIDTH, 32, sum port width; must be >= WIDTH+1.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  OUT_WIDTH  result {zeros, cout, a+b+cin[WIDTH-1:0]}.
cout  output  1  final carry-out (duplicate of sum[WIDTH]).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Derived constant: N = WIDTH/DIGIT steps.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, step counter=0, carry register=0.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, capture a and b into shift registers and cin into the carry register, clear the counter, and go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: add the low DIGIT bits of both shift registers plus the carry register.
  - Shift the DIGIT-bit result into the top of the result register (shift right). Shift the operands right by DIGIT.
  - Store the slice carry-out into the carry register and increment the counter.
  - On the edge where the counter reaches N-1 (the Nth step), go to DONE.
  - Inputs a, b, cin and in_valid are ignored while in RUN.
- DONE:
  - out_valid=1.
  - sum = zero-extended {carry, result}; cout = carry.
  - sum and cout stay stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. sum and cout keep their last value.
- Latency: out_valid rises N cycles after the acceptance edge.
- Throughput: with out_ready held high, one operation per N+2 cycles. There is no overlap of accept and complete.
- Width rules:
  - sum[WIDTH-1:0] = (a+b+cin) mod 2^WIDTH.
  - sum[WIDTH] = carry-out.
  - sum[OUT_WIDTH-1:WIDTH+1] = 0.
- Boundary conditions:
  - Reset asserted in RUN or DONE aborts the operation on that edge. All outputs return to reset values and no result is produced.
  - Reset has priority over every handshake.
  - out_ready asserted outside DONE has no effect.
  - DIGIT=WIDTH gives N=1: one RUN cycle.
  - Elaboration must fail (generate-time check) if WIDTH % DIGIT != 0 or OUT_WIDTH < WIDTH+1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, valid with out_valid and held like sum.
  - ovf = signed two's-complement overflow = carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is captured during the final RUN step.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16, DIGIT=4, N=4 unless noted):
1. a=0x0000, b=0x0000, cin=0 accepted at edge E0 -> out_valid rises after edge E4; sum=0x00000000, cout=0; in_ready=0 from E0 until return to IDLE.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x00010000, cout=1 (carry ripples through all 4 digit steps).
3. a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x0001FFFF, cout=1. Then a=0x1234, b=0x4321, cin=0 -> sum=0x00005555, cout=0.
4. Backpressure: result ready, out_ready held 0 for 5 cycles -> out_valid stays 1, sum unchanged, in_ready=0. Raise out_ready -> IDLE next edge. Also toggle a/b/in_valid during RUN -> result unaffected.
5. Reset asserted on the 2nd RUN cycle -> next edge state IDLE, out_valid=0, sum=0, in_ready=1. Then a=0x00FF, b=0x0001, cin=0 -> sum=0x00000100.
6. With SERIAL_ADDER_OVF_EN:
   - a=0x7FFF, b=0x0001 -> ovf=1, cout=0.
   - a=0x8000, b=0x8000 -> ovf=1, sum=0x00010000.
   - Repeat scenarios 2 and 3 with DIGIT=1 (N=16, latency 16) and DIGIT=16 (N=1, latency 1) -> identical sums.
